rr_packet_arbiter: RTL and testbench
====================================

// Module: rr_packet_arbiter
// PURPOSE
//  Round-robin arbiter sharing one valid/ready output stream among NUM_REQ upstream requesters.
//  Grant is locked for a whole packet (until the beat with last=1 is accepted), then passes on.
//  Output goes through an internal 2-entry skid stage: upstream readies come from registers only,
//  with no combinational path from i_data_ready. Sits in front of a shared downstream stage.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  DWIDTH   8  data width per beat
//  IDWIDTH  2  width of o_data_id; must be >= clog2(NUM_REQ)
// PORTS
//  i_clock       in   1               single clock, all logic on rising edge
//  i_reset_n     in   1               asynchronous, active-low reset
//  i_data        in   NUM_REQ*DWIDTH  requester k data at [k*DWIDTH +: DWIDTH]
//  i_data_valid  in   NUM_REQ         per-requester valid
//  i_data_last   in   NUM_REQ         per-requester end-of-packet flag, qualified by valid
//  o_data_ready  out  NUM_REQ         per-requester ready (registered)
//  o_data        out  DWIDTH          output beat data
//  o_data_last   out  1               output end-of-packet flag
//  o_data_id     out  IDWIDTH         index of the requester that sourced the beat
//  o_data_valid  out  1               output valid
//  i_data_ready  in   1               downstream ready
//  o_busy        out  1               1 = packet locked or skid stage not empty
// BEHAVIOUR
//  Reset (i_reset_n=0, async): state IDLE, rr pointer=0, skid stage empty.
//   All outputs are 0 (o_data_ready, o_data, o_data_last, o_data_id, o_data_valid, o_busy).
//  FSM IDLE:
//   - If any i_data_valid=1, grant g = first k with valid set, searching from the rr pointer
//     upward modulo NUM_REQ. g is registered and the FSM goes to LOCKED next cycle.
//   - With no valid, stay in IDLE. All o_data_ready=0 in IDLE.
//  FSM LOCKED:
//   - o_data_ready[g] = stage_ready. All other o_data_ready bits are 0.
//   - A beat is accepted when i_data_valid[g] & o_data_ready[g]; {data, last, g} is pushed
//     into the skid stage.
//   - Accepted beat with last=1: next cycle FSM=IDLE, rr pointer=(g+1) mod NUM_REQ, ready deasserts.
//   - If valid drops mid-packet, the grant is held. There is no timeout and no pre-emption.
//  Arbitration bubble: one idle cycle between packets. A 1-beat packet costs 2 cycles of grant.
//  Skid stage: 2-entry FIFO of {DWIDTH data, last, IDWIDTH id}.
//   - Occupancy counter 0..2 is a register. stage_ready = (occupancy<2), decoded from that register.
//   - Head drives o_data/o_data_last/o_data_id; o_data_valid = (occupancy!=0).
//   - Pop when o_data_valid & i_data_ready. Push and pop in the same cycle leaves occupancy unchanged.
//   - Order is preserved; no beat is lost or duplicated.
//   - o_data/o_data_id hold stable while o_data_valid=1 & i_data_ready=0.
//   - After a pop empties the stage, o_data_* hold their last values.
//  Latency: accepted beat appears on o_data_valid the next cycle when the stage was empty.
//   Sustained 1 beat/cycle while i_data_ready=1.
//  Upstream rule: requester holds data/last stable while valid=1 and not accepted.
//   i_data_last with valid=0 is ignored.
//  o_busy = (state==LOCKED) | (occupancy!=0).
//  Reset mid-operation: in-flight packet and stage contents discarded. After release,
//   arbitration restarts from pointer 0.
// TESTING
//  1 Hold i_reset_n=0 and drive random inputs -> every output is 0. Release with no valid
//    -> o_busy stays 0.
//  2 Req0 sends 0xA1,0xA2,0xA3 (last on 0xA3), i_data_ready=1 -> o_data A1,A2,A3 on consecutive
//    cycles, id=0, o_data_last only with A3, ready[0] drops after A3.
//  3 Reqs 0..3 all continuously valid with 1-beat packets -> o_data_id order 0,1,2,3,0,1;
//    only one o_data_ready bit high at a time.
//  4 Req1 streams 0x10..0x15 with i_data_ready=0 -> exactly 2 beats accepted, o_data_ready[1]=0,
//    o_data=0x10 held. Raise ready -> 0x10..0x15 delivered in order.
//  5 Req0 4-beat packet with 2-cycle valid gap after beat 2, req2 valid throughout -> req2 not
//    granted until req0 last beat is accepted, then id=2 follows.
//  6 Assert i_reset_n=0 during beat 2 of a req3 packet -> outputs 0 immediately, no clock needed.
//    After release, req0 and req3 both valid -> req0 granted first.

Source files
------------

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grant held per packet, output through a
// 2-entry skid stage so upstream readies never see i_data_ready combinationally.
module rr_packet_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8,
  parameter int IDWIDTH = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ*DWIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]        i_data_valid,
  input  logic [NUM_REQ-1:0]        i_data_last,
  output logic [NUM_REQ-1:0]        o_data_ready,
  output logic [DWIDTH-1:0]         o_data,
  output logic                      o_data_last,
  output logic [IDWIDTH-1:0]        o_data_id,
  output logic                      o_data_valid,
  input  logic                      i_data_ready,
  output logic                      o_busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDWIDTH-1:0] r_grant;
  logic [IDWIDTH-1:0] w_grant_nxt;
  logic [IDWIDTH-1:0] r_ptr;
  logic [IDWIDTH-1:0] w_ptr_nxt;
  logic [IDWIDTH-1:0] w_idx;
  logic [IDWIDTH-1:0] w_pick;
  logic               w_found;

  logic [1:0]         r_cnt;
  logic [1:0]         w_cnt_nxt;
  logic [DWIDTH-1:0]  r_hd_data;
  logic [DWIDTH-1:0]  r_tl_data;
  logic               r_hd_last;
  logic               r_tl_last;
  logic [IDWIDTH-1:0] r_hd_id;
  logic [IDWIDTH-1:0] r_tl_id;

  logic [NUM_REQ-1:0] r_ready;
  logic [NUM_REQ-1:0] w_ready_nxt;
  logic [DWIDTH-1:0]  w_in_data;
  logic               w_in_last;
  logic               w_sel_valid;
  logic               w_sel_rdy;
  logic               w_push;
  logic               w_pop;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_found && (w_idx == IDWIDTH'(k)) && i_data_valid[k]) begin
          w_found = 1'b1;
          w_pick  = w_idx;
        end
      end
      w_idx = (w_idx == IDWIDTH'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rdy   = 1'b0;
    w_in_last   = 1'b0;
    w_in_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant == IDWIDTH'(k)) begin
        w_sel_valid = i_data_valid[k];
        w_sel_rdy   = r_ready[k];
        w_in_last   = i_data_last[k];
        w_in_data   = i_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_push = w_sel_valid & w_sel_rdy;
  assign w_pop  = (r_cnt != 2'd0) & i_data_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOCKED;
          w_grant_nxt = w_pick;
        end
      end
      S_LOCKED: begin
        if (w_push && w_in_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = (r_grant == IDWIDTH'(NUM_REQ-1)) ?
                        '0 : r_grant + 1'b1;
        end
      end
    endcase
  end

  // Ready is the registered image of next state/grant/occupancy.
  always_comb begin
    w_ready_nxt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if ((w_state_nxt == S_LOCKED) && (w_cnt_nxt < 2'd2) &&
          (w_grant_nxt == IDWIDTH'(k))) begin
        w_ready_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_ready   <= '0;
      r_cnt     <= 2'd0;
      r_hd_data <= '0;
      r_hd_last <= 1'b0;
      r_hd_id   <= '0;
      r_tl_data <= '0;
      r_tl_last <= 1'b0;
      r_tl_id   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))) begin
        r_hd_data <= w_in_data;
        r_hd_last <= w_in_last;
        r_hd_id   <= r_grant;
      end else if (w_pop && (r_cnt == 2'd2)) begin
        r_hd_data <= r_tl_data;
        r_hd_last <= r_tl_last;
        r_hd_id   <= r_tl_id;
      end
      if (w_push && (r_cnt == 2'd1) && !w_pop) begin
        r_tl_data <= w_in_data;
        r_tl_last <= w_in_last;
        r_tl_id   <= r_grant;
      end
    end
  end

  assign o_data_ready = r_ready;
  assign o_data       = r_hd_data;
  assign o_data_last  = r_hd_last;
  assign o_data_id    = r_hd_id;
  assign o_data_valid = (r_cnt != 2'd0);
  assign o_busy       = (r_state == S_LOCKED) | (r_cnt != 2'd0);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: scripted requester streams,
// captured output beats compared against hand-computed sequences.
module tb_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic [3:0]  vin;
  logic [3:0]  lin;
  logic [3:0]  rdy_up;
  logic [7:0]  dout;
  logic        dlast;
  logic [1:0]  did;
  logic        dvalid;
  logic        rdy_dn;
  logic        busy;

  always #5 clk = ~clk;

  rr_packet_arbiter #(.NUM_REQ(4), .DWIDTH(8), .IDWIDTH(2)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_data       (din),
    .i_data_valid (vin),
    .i_data_last  (lin),
    .o_data_ready (rdy_up),
    .o_data       (dout),
    .o_data_last  (dlast),
    .o_data_id    (did),
    .o_data_valid (dvalid),
    .i_data_ready (rdy_dn),
    .o_busy       (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int multi_rdy = 0;
  int stray_rdy = 0;
  int early2 = 0;
  bit watch2 = 0;

  logic [7:0] src_data [4][16];
  logic       src_last [4][16];
  int         len [4];
  int         pos [4];
  bit         en [4];

  logic [7:0] out_d [64];
  logic [1:0] out_id [64];
  logic       out_l [64];
  int         out_c [64];
  int         n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (en[k] && pos[k] < len[k]) begin
        vin[k] = 1'b1;
        din[k*8 +: 8] = src_data[k][pos[k]];
        lin[k] = src_last[k][pos[k]];
      end else begin
        vin[k] = 1'b0;
        lin[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    if (dvalid && rdy_dn && n_out < 64) begin
      out_d[n_out] = dout;
      out_id[n_out] = did;
      out_l[n_out] = dlast;
      out_c[n_out] = cyc;
      n_out++;
    end
    if ($countones(rdy_up) > 1) multi_rdy++;
    for (int k = 0; k < 4; k++)
      if (rdy_up[k] && pos[k] >= len[k]) stray_rdy++;
    if (watch2 && rdy_up[2] && pos[0] < len[0]) early2++;
    acc = vin & rdy_up;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++)
      if (acc[k]) pos[k]++;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en[k] = 0;
      len[k] = 0;
      pos[k] = 0;
    end
    n_out = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0;
    vin = '0;
    lin = '0;
    rdy_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en[k] = 0;
      len[k] = 0;
      pos[k] = 0;
    end

    // 1: outputs zero under reset with random inputs
    for (int i = 0; i < 5; i++) begin
      din = $urandom;
      vin = 4'($urandom);
      lin = 4'($urandom);
      rdy_dn = 1'($urandom);
      #7;
      check("rst_outs", {15'd0, rdy_up, dout, dlast, did, dvalid, busy}, 32'd0);
    end
    vin = '0;
    lin = '0;
    rdy_dn = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_busy", busy, 0);
    check("idle_valid", dvalid, 0);
    check("idle_rdy", rdy_up, 0);

    // 2: three-beat packet from req0
    src_data[0][0] = 8'hA1; src_last[0][0] = 0;
    src_data[0][1] = 8'hA2; src_last[0][1] = 0;
    src_data[0][2] = 8'hA3; src_last[0][2] = 1;
    len[0] = 3; pos[0] = 0; en[0] = 1; n_out = 0;
    drive();
    repeat (8) tick();
    check("t2_nout", n_out, 3);
    check("t2_d0", out_d[0], 8'hA1);
    check("t2_d1", out_d[1], 8'hA2);
    check("t2_d2", out_d[2], 8'hA3);
    check("t2_id", {out_id[0], out_id[1], out_id[2]}, 0);
    check("t2_last", {out_l[0], out_l[1], out_l[2]}, 3'b001);
    check("t2_gap01", out_c[1] - out_c[0], 1);
    check("t2_gap12", out_c[2] - out_c[1], 1);
    check("t2_rdy_off", rdy_up, 0);
    check("t2_busy", busy, 0);

    // 3: all four requesters, single-beat packets
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src_data[k][0] = 8'h30 + 8'(k); src_last[k][0] = 1;
      src_data[k][1] = 8'h40 + 8'(k); src_last[k][1] = 1;
      len[k] = 2;
      en[k] = 1;
    end
    drive();
    repeat (24) tick();
    check("t3_nout", n_out, 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_id", out_id[i], i % 4);
      check("t3_data", out_d[i], (i < 4) ? 8'h30 + i : 8'h40 + i - 4);
    end
    check("t3_bubble", out_c[1] - out_c[0], 2);

    // 4: downstream stalled, skid stage fills to two
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src_data[1][i] = 8'h10 + 8'(i);
      src_last[1][i] = (i == 5);
    end
    len[1] = 6;
    en[1] = 1;
    rdy_dn = 1'b0;
    drive();
    repeat (8) tick();
    check("t4_accepted", pos[1], 2);
    check("t4_rdy1", rdy_up[1], 0);
    check("t4_hold", dout, 8'h10);
    check("t4_valid", dvalid, 1);
    check("t4_nout", n_out, 0);
    rdy_dn = 1'b1;
    repeat (12) tick();
    check("t4_nout2", n_out, 6);
    for (int i = 0; i < 6; i++) begin
      check("t4_data", out_d[i], 8'h10 + i);
      check("t4_last", out_l[i], (i == 5) ? 1 : 0);
    end

    // 5: valid gap inside a req0 packet must not let req2 in
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_data[0][i] = 8'h50 + 8'(i);
      src_last[0][i] = (i == 3);
    end
    src_data[2][0] = 8'h60; src_last[2][0] = 1;
    len[0] = 4; len[2] = 1;
    en[0] = 1; en[2] = 1;
    watch2 = 1;
    drive();
    for (int t = 0; t < 20 && pos[0] < 2; t++) tick();
    check("t5_pos2", pos[0], 2);
    en[0] = 0;
    drive();
    repeat (2) tick();
    check("t5_rdy2_gap", rdy_up[2], 0);
    en[0] = 1;
    drive();
    for (int t = 0; t < 20 && pos[0] < 4; t++) tick();
    check("t5_pos4", pos[0], 4);
    repeat (6) tick();
    watch2 = 0;
    check("t5_early2", early2, 0);
    check("t5_nout", n_out, 5);
    check("t5_d3", out_d[3], 8'h53);
    check("t5_id3", out_id[3], 0);
    check("t5_d4", out_d[4], 8'h60);
    check("t5_id4", out_id[4], 2);

    // 6: async reset mid-packet, then restart from pointer 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src_data[3][i] = 8'h70 + 8'(i);
      src_last[3][i] = (i == 2);
    end
    len[3] = 3;
    en[3] = 1;
    drive();
    for (int t = 0; t < 20 && pos[3] < 1; t++) tick();
    check("t6_pos1", pos[3], 1);
    check("t6_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", {15'd0, rdy_up, dout, dlast, did, dvalid, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      pos[k] = 0;
      len[k] = 0;
      en[k] = 0;
    end
    src_data[0][0] = 8'h80; src_last[0][0] = 1;
    src_data[3][0] = 8'h90; src_last[3][0] = 1;
    len[0] = 1; len[3] = 1;
    en[0] = 1; en[3] = 1;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    n_out = 0;
    repeat (10) tick();
    check("t6_nout", n_out, 2);
    check("t6_id0", out_id[0], 0);
    check("t6_d0", out_d[0], 8'h80);
    check("t6_id1", out_id[1], 3);
    check("t6_d1", out_d[1], 8'h90);

    check("onehot_rdy", multi_rdy, 0);
    check("stray_rdy", stray_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
